// File: rtl/mac_array_sched.sv
// mac_array_sched: feeds a rows x cols MAC array with skewed operand waves.
// Each accepted operand beat (one column of A, one row of B) enters lane 0
// directly and lane j through a j-deep delay line, so wave t presents beat
// t-j on lane j. After the last wave the block waits for every PE to report
// a result, then offers it for one yumi.
// Optional feature: define MAC_SCHED_TIMEOUT_EN to add a DRAIN watchdog that
// raises a sticky error_o and abandons the product if results never arrive.
//
// Handshakes: a beat moves on a channel in any cycle where its valid and
// ready are both high. No valid output depends on its own ready. The skewed
// lanes advance together: a wave (and every lane beat in it) is consumed
// only in a cycle where every valid lane sees ready, plus ab_valid_i while
// beats are still being accepted. Until then all lane outputs hold.
module mac_array_sched #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int klen_width_p   = 16
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     start_i,
  input  logic [klen_width_p-1:0]                  k_len_i,
  input  logic [width_p*array_height_p-1:0]        a_i,
  input  logic [width_p*array_width_p-1:0]         b_i,
  input  logic                                     ab_valid_i,
  output logic                                     ab_ready_o,
  output logic [width_p*array_height_p-1:0]        row_o,
  output logic [array_height_p-1:0]                row_valid_o,
  input  logic [array_height_p-1:0]                row_ready_i,
  output logic [width_p*array_width_p-1:0]         col_o,
  output logic [array_width_p-1:0]                 col_valid_o,
  input  logic [array_width_p-1:0]                 col_ready_i,
  input  logic [array_width_p*array_height_p-1:0]  z_valid_i,
  output logic [array_width_p*array_height_p-1:0]  z_yumi_o,
  output logic                                     busy_o,
  output logic                                     result_v_o,
  input  logic                                     result_yumi_i,
  output logic                                     error_o,
  output logic [1:0]                               state_o
);

  localparam int max_dim_lp = (array_width_p > array_height_p) ? array_width_p : array_height_p;
  localparam int t_width_lp = klen_width_p + $clog2(max_dim_lp + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [klen_width_p-1:0] k_q, k_d;
  logic [t_width_lp-1:0]   t_q, t_d;
  logic [t_width_lp-1:0]   k_ext, t_last;
  logic                    feeding, beat_phase, lanes_ok, wave_fire, wd_hit;
  logic [array_height_p-1:0] row_want;
  logic [array_width_p-1:0]  col_want;

  assign k_ext      = t_width_lp'(k_q);
  assign t_last     = k_ext + t_width_lp'(max_dim_lp) - t_width_lp'(2);
  assign feeding    = (state_q == S_FEED);
  assign beat_phase = feeding && (t_q < k_ext);
  assign state_o    = state_q;
  assign busy_o     = (state_q != S_IDLE);

  // Lane j is live in wave t when it carries beat t-j with 0 <= t-j < K.
  always_comb begin
    row_want = '0;
    col_want = '0;
    for (int j = 0; j < array_height_p; j++)
      row_want[j] = feeding && (t_q >= t_width_lp'(j)) && (t_q < k_ext + t_width_lp'(j));
    for (int j = 0; j < array_width_p; j++)
      col_want[j] = feeding && (t_q >= t_width_lp'(j)) && (t_q < k_ext + t_width_lp'(j));
  end

  assign lanes_ok   = (&(~row_want | row_ready_i)) && (&(~col_want | col_ready_i));
  assign ab_ready_o = beat_phase && lanes_ok;
  assign wave_fire  = feeding && lanes_ok && (!beat_phase || ab_valid_i);

  // Lane 0 shows the incoming beat, so its valid also waits on ab_valid_i.
  always_comb begin
    row_valid_o    = row_want;
    col_valid_o    = col_want;
    row_valid_o[0] = row_want[0] && ab_valid_i;
    col_valid_o[0] = col_want[0] && ab_valid_i;
  end

  assign row_o[width_p-1:0] = row_valid_o[0] ? a_i[width_p-1:0] : '0;
  assign col_o[width_p-1:0] = col_valid_o[0] ? b_i[width_p-1:0] : '0;

  for (genvar j = 1; j < array_height_p; j++) begin : g_row_dl
    logic [width_p-1:0] dl_q [j];
    logic [width_p-1:0] lane_in;
    assign lane_in = beat_phase ? a_i[width_p*j +: width_p] : '0;
    // Shift the row delay line once per issued wave.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        for (int s = 0; s < j; s++) dl_q[s] <= '0;
      end else if (wave_fire) begin
        dl_q[0] <= lane_in;
        for (int s = 1; s < j; s++) dl_q[s] <= dl_q[s-1];
      end
    end
    assign row_o[width_p*j +: width_p] = row_want[j] ? dl_q[j-1] : '0;
  end

  for (genvar j = 1; j < array_width_p; j++) begin : g_col_dl
    logic [width_p-1:0] dl_q [j];
    logic [width_p-1:0] lane_in;
    assign lane_in = beat_phase ? b_i[width_p*j +: width_p] : '0;
    // Shift the column delay line once per issued wave.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        for (int s = 0; s < j; s++) dl_q[s] <= '0;
      end else if (wave_fire) begin
        dl_q[0] <= lane_in;
        for (int s = 1; s < j; s++) dl_q[s] <= dl_q[s-1];
      end
    end
    assign col_o[width_p*j +: width_p] = col_want[j] ? dl_q[j-1] : '0;
  end

`ifdef MAC_SCHED_TIMEOUT_EN
  localparam int wd_limit_lp = 4 * (array_width_p + array_height_p);
  localparam int wd_width_lp = $clog2(wd_limit_lp + 1);

  logic [wd_width_lp-1:0] wd_q, wd_d;
  logic                   error_q;

  // A result arriving on the final watchdog cycle still wins over the timeout.
  assign wd_hit  = (state_q == S_DRAIN) && !(&z_valid_i) &&
                   (wd_q == wd_width_lp'(wd_limit_lp - 1));
  assign wd_d    = (state_q == S_DRAIN) ? wd_q + 1'b1 : '0;
  assign error_o = error_q;

  // Count DRAIN cycles; the error flag is sticky until reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_q | wd_hit;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign error_o = 1'b0;
`endif

  // Next-state, K/t bookkeeping and result handshake.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    t_d        = t_q;
    z_yumi_o   = '0;
    result_v_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && (k_len_i != '0)) begin
          state_d = S_FEED;
          k_d     = k_len_i;
          t_d     = '0;
        end
      end
      S_FEED: begin
        if (wave_fire) begin
          t_d = t_q + 1'b1;
          if (t_q == t_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (&z_valid_i)  state_d = S_DONE;
        else if (wd_hit) state_d = S_IDLE;
      end
      S_DONE: begin
        result_v_o = 1'b1;
        if (result_yumi_i) begin
          z_yumi_o = '1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, K and wave-counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
    end
  end

endmodule

// File: tb/tb_mac_array_sched.sv
// Directed bench for mac_array_sched (2x2, 32-bit). Lane beats seen at each
// issued wave are collected and multiplied out to form the products the
// array would hold; those are compared against hand-computed values.
module tb_mac_array_sched;

  localparam int W  = 32;
  localparam int AW = 2;
  localparam int AH = 2;
  localparam int KW = 16;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic              clk, rst, start, ab_valid, ab_ready;
  logic [KW-1:0]     k_len;
  logic [W*AH-1:0]   a_in, row_o;
  logic [W*AW-1:0]   b_in, col_o;
  logic [AH-1:0]     row_valid, row_ready;
  logic [AW-1:0]     col_valid, col_ready;
  logic [AW*AH-1:0]  z_valid, z_yumi;
  logic              busy, result_v, result_yumi, error;
  logic [1:0]        state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [1:0]  ew_rv[3];
  logic [63:0] ew_row[3], ew_col[3], a_beat[2], b_beat[2];
  logic [31:0] rb[AH][4], cb[AW][4];
  int          rcnt[AH], ccnt[AW];

  mac_array_sched #(.width_p(W), .array_width_p(AW), .array_height_p(AH), .klen_width_p(KW)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .k_len_i(k_len),
    .a_i(a_in), .b_i(b_in), .ab_valid_i(ab_valid), .ab_ready_o(ab_ready),
    .row_o(row_o), .row_valid_o(row_valid), .row_ready_i(row_ready),
    .col_o(col_o), .col_valid_o(col_valid), .col_ready_i(col_ready),
    .z_valid_i(z_valid), .z_yumi_o(z_yumi), .busy_o(busy), .result_v_o(result_v),
    .result_yumi_i(result_yumi), .error_o(error), .state_o(state)
  );

  // Clock and global time bound.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ab_ready"}, ab_ready, 0);
    check({tag, "_row_valid"}, row_valid, 0);
    check({tag, "_col_valid"}, col_valid, 0);
    check({tag, "_row_data"}, row_o, 0);
    check({tag, "_col_data"}, col_o, 0);
    check({tag, "_z_yumi"}, z_yumi, 0);
    check({tag, "_result_v"}, result_v, 0);
    check({tag, "_error"}, error, 0);
  endtask

  task automatic check_wave(input int w, input logic exp_ready);
    check($sformatf("w%0d_row_valid", w), row_valid, ew_rv[w]);
    check($sformatf("w%0d_col_valid", w), col_valid, ew_rv[w]);
    check($sformatf("w%0d_row_data", w), row_o, ew_row[w]);
    check($sformatf("w%0d_col_data", w), col_o, ew_col[w]);
    check($sformatf("w%0d_ab_ready", w), ab_ready, exp_ready);
    check($sformatf("w%0d_state", w), state, ST_FEED);
  endtask

  // Capture lane beats in a cycle where the whole wave can issue.
  task automatic record_wave();
    logic ok;
    ok = (&(~row_valid | row_ready)) && (&(~col_valid | col_ready));
    if (ok) begin
      for (int i = 0; i < AH; i++)
        if (row_valid[i] && rcnt[i] < 4) begin rb[i][rcnt[i]] = row_o[W*i +: W]; rcnt[i]++; end
      for (int j = 0; j < AW; j++)
        if (col_valid[j] && ccnt[j] < 4) begin cb[j][ccnt[j]] = col_o[W*j +: W]; ccnt[j]++; end
    end
  endtask

  // Products the array would accumulate from the captured beats.
  task automatic check_results(input string tag);
    int          acc;
    logic [31:0] acc_v;
    for (int i = 0; i < AH; i++) check($sformatf("%s_row%0d_beats", tag, i), rcnt[i], 2);
    for (int j = 0; j < AW; j++) check($sformatf("%s_col%0d_beats", tag, j), ccnt[j], 2);
    exp_q.push_back(32'hFFFF_F7C9);  // -2103
    exp_q.push_back(32'hFFFF_F185);  // -3707
    exp_q.push_back(32'd21950);
    exp_q.push_back(32'd30);
    for (int i = 0; i < AH; i++)
      for (int j = 0; j < AW; j++) begin
        acc = 0;
        for (int k = 0; k < 2; k++) acc += $signed(rb[i][k]) * $signed(cb[j][k]);
        acc_v = acc;
        check($sformatf("%s_c%0d%0d", tag, i, j), acc_v, exp_q.pop_front());
      end
  endtask

  // One K=2 product. mode 0: plain, 1: lane-1 row stall in wave 1,
  // 2: stop once DRAIN is reached.
  task automatic full_run(input int mode, input string tag);
    for (int i = 0; i < AH; i++) rcnt[i] = 0;
    for (int j = 0; j < AW; j++) ccnt[j] = 0;
    row_ready = '1;
    col_ready = '1;
    start = 1'b1;
    k_len = 16'd2;
    tick();
    start = 1'b0;
    a_in = a_beat[0];
    b_in = b_beat[0];
    ab_valid = 1'b1;
    settle();
    check({tag, "_busy"}, busy, 1);
    check_wave(0, 1'b1);
    record_wave();
    tick();
    a_in = a_beat[1];
    b_in = b_beat[1];
    if (mode == 1) begin
      row_ready = 2'b01;
      settle();
      for (int c = 0; c < 3; c++) begin
        check_wave(1, 1'b0);
        record_wave();
        tick();
      end
      row_ready = '1;
    end
    settle();
    check_wave(1, 1'b1);
    record_wave();
    tick();
    a_in = '0;
    b_in = '0;
    ab_valid = 1'b0;
    settle();
    check_wave(2, 1'b0);
    record_wave();
    tick();
    check({tag, "_drain_state"}, state, ST_DRAIN);
    check({tag, "_drain_valids"}, {row_valid, col_valid}, 0);
    check({tag, "_drain_busy"}, busy, 1);
    if (mode != 2) begin
      start = 1'b1;
      k_len = 16'd5;
      tick();
      start = 1'b0;
      check({tag, "_busy_start_ignored"}, state, ST_DRAIN);
      z_valid = '1;
      tick();
      z_valid = '0;
      settle();
      check({tag, "_done_state"}, state, ST_DONE);
      check({tag, "_done_result_v"}, result_v, 1);
      for (int c = 0; c < 5; c++) begin
        tick();
        check({tag, "_hold_result_v"}, result_v, 1);
        check({tag, "_hold_z_yumi"}, z_yumi, 0);
      end
      result_yumi = 1'b1;
      settle();
      check({tag, "_yumi_all_ones"}, z_yumi, 4'hF);
      tick();
      result_yumi = 1'b0;
      settle();
      check({tag, "_after_state"}, state, ST_IDLE);
      check({tag, "_after_busy"}, busy, 0);
      check({tag, "_after_result_v"}, result_v, 0);
      check({tag, "_after_z_yumi"}, z_yumi, 0);
      check_results(tag);
    end
  endtask

  initial begin
    int   n;
    logic zy_seen;
    ew_rv[0] = 2'b01;  ew_rv[1] = 2'b11;  ew_rv[2] = 2'b10;
    // Beat fed first is A column 1 / B row 1, then A column 0 / B row 0.
    a_beat[0] = {32'd960, 32'd44};
    a_beat[1] = {32'd10, 32'hFFFF_FFDB};
    b_beat[0] = {32'hFFFF_FFFF, 32'd22};
    b_beat[1] = {32'd99, 32'd83};
    ew_row[0] = {32'd0, 32'd44};
    ew_row[1] = {32'd960, 32'hFFFF_FFDB};
    ew_row[2] = {32'd10, 32'd0};
    ew_col[0] = {32'd0, 32'd22};
    ew_col[1] = {32'hFFFF_FFFF, 32'd83};
    ew_col[2] = {32'd99, 32'd0};

    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    a_in = '0;
    b_in = '0;
    ab_valid = 1'b0;
    row_ready = '1;
    col_ready = '1;
    z_valid = '0;
    result_yumi = 1'b0;

    // Reset: quiet outputs, start ignored while reset is held.
    tick();
    start = 1'b1;
    k_len = 16'd2;
    tick();
    check_quiet("reset");
    check("reset_state", state, ST_IDLE);
    start = 1'b0;
    rst = 1'b0;
    tick();

    full_run(0, "basic");
    full_run(1, "stall");

    // K=0 start is ignored.
    start = 1'b1;
    k_len = 16'd0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("k0_busy", busy, 0);
      check("k0_valids", {row_valid, col_valid}, 0);
      tick();
    end

    // Reset in the middle of FEED, after waves 0 and 1 have issued.
    start = 1'b1;
    k_len = 16'd2;
    tick();
    start = 1'b0;
    a_in = a_beat[0];
    b_in = b_beat[0];
    ab_valid = 1'b1;
    tick();
    a_in = a_beat[1];
    b_in = b_beat[1];
    tick();
    check("midfeed_state", state, ST_FEED);
    rst = 1'b1;
    settle();
    check_quiet("rst_async");
    tick();
    check_quiet("rst_next");
    rst = 1'b0;
    ab_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    tick();
    check("rst_idle", state, ST_IDLE);
    full_run(0, "post_reset");

    // DRAIN with no results.
    full_run(2, "drain");
    zy_seen = 1'b0;
`ifdef MAC_SCHED_TIMEOUT_EN
    n = 0;
    while (!error && n < 40) begin
      tick();
      n++;
      if (z_yumi != '0) zy_seen = 1'b1;
    end
    check("wd_cycles", n, 16);
    check("wd_state", state, ST_IDLE);
    check("wd_busy", busy, 0);
    check("wd_no_yumi", zy_seen, 0);
    repeat (3) tick();
    check("wd_sticky", error, 1);
    rst = 1'b1;
    settle();
    check("wd_cleared", error, 0);
    tick();
    rst = 1'b0;
    tick();
`else
    n = 0;
    repeat (20) begin
      tick();
      n++;
      if (z_yumi != '0) zy_seen = 1'b1;
    end
    check("nowd_state", state, ST_DRAIN);
    check("nowd_error", error, 0);
    check("nowd_no_yumi", zy_seen, 0);
    rst = 1'b1;
    settle();
    check_quiet("nowd_reset");
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
